// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: opcodes, state encodings and defaults shared by the
// memory-access controller, its timer and any memory model or bench.
package mem_access_ctrl_pkg;
    localparam logic [5:0]  OP_LW        = 6'b100011;
    localparam logic [5:0]  OP_SW        = 6'b101011;
    localparam int          DMEM_SIZE    = 1024;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        MEM_DONE = 2'd3
    } mem_state_t;
    function automatic logic is_mem_op(input logic [5:0] op);
        return op == OP_LW || op == OP_SW;
    endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: saturating wait counter with clear, enable and terminal count.
module mem_wait_timer #(
    parameter int MAX = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = $clog2(MAX + 1);
    logic [W-1:0] cnt;
    assign tc = cnt == W'(MAX);
    always_ff @(posedge CLK) begin
        if (RST || clr) cnt <= '0;
        else if (en && !tc) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns LW/SW into handshaked requests on a multi-cycle data
// bus, stalling the datapath until the access completes or times out.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Ins,
    input  logic [31:0] Adr,
    input  logic [31:0] Wdata,
    output logic [31:0] Rdata,
    output logic        Stall,
    output logic        Err,
    output logic        MReq,
    output logic        MWe,
    output logic [31:0] MAdr,
    output logic [31:0] MWdata,
    input  logic        MGnt,
    input  logic        MRvalid,
    input  logic [31:0] MRdata
);
    mem_state_t  state;
    logic [31:0] cap;
    logic        tc;
    logic [5:0]  op;
    logic        mem;
    logic        unused_ins;
    assign op         = Ins[31:26];
    assign mem        = is_mem_op(op);
    assign unused_ins = ^Ins[25:0];
    assign Stall = state == MEM_IDLE ? mem : state != MEM_DONE;
    assign Rdata = (state == MEM_IDLE && !mem) ? Adr : state == MEM_DONE ? cap : 32'h0;
    mem_wait_timer #(.MAX(TIMEOUT)) u_timer (
        .CLK (CLK),
        .RST (RST),
        .clr (state == MEM_IDLE),
        .en  (state == MEM_REQ ? !MGnt && !tc : state == MEM_WAIT && !MRvalid && !tc),
        .tc  (tc)
    );
    // cap doubles as the DONE result, so SW paths load it with 0
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= MEM_IDLE;
            MReq   <= 1'b0;
            MWe    <= 1'b0;
            MAdr   <= 32'h0;
            MWdata <= 32'h0;
            Err    <= 1'b0;
            cap    <= 32'h0;
        end else begin
            case (state)
                MEM_IDLE: if (mem) begin
                    if (Adr[1:0] != 2'b00) begin
                        Err   <= 1'b1;
                        cap   <= op == OP_SW ? 32'h0 : ERR_DATA;
                        state <= MEM_DONE;
                    end else begin
                        MReq   <= 1'b1;
                        MWe    <= op == OP_SW;
                        MAdr   <= Adr;
                        MWdata <= Wdata;
                        cap    <= 32'h0;
                        state  <= MEM_REQ;
                    end
                end
                MEM_REQ: if (MGnt) begin
                    MReq <= 1'b0;
                    if (MWe) state <= MEM_DONE;
                    else if (MRvalid) begin
                        cap   <= MRdata;
                        state <= MEM_DONE;
                    end else state <= MEM_WAIT;
                end else if (tc) begin
                    MReq  <= 1'b0;
                    Err   <= 1'b1;
                    cap   <= MWe ? 32'h0 : ERR_DATA;
                    state <= MEM_DONE;
                end
                MEM_WAIT: if (MRvalid) begin
                    cap   <= MRdata;
                    state <= MEM_DONE;
                end else if (tc) begin
                    Err   <= 1'b1;
                    cap   <= ERR_DATA;
                    state <= MEM_DONE;
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vectors against hand-computed expectations.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] Ins = 32'h0, Adr = 32'h0, Wdata = 32'h0, MRdata = 32'h0;
    logic        MGnt = 1'b0, MRvalid = 1'b0;
    logic [31:0] Rdata, MAdr, MWdata;
    logic        Stall, Err, MReq, MWe;
    int checks = 0, errors = 0;
    localparam logic [31:0] I_LW  = {OP_LW, 26'h0};
    localparam logic [31:0] I_SW  = {OP_SW, 26'h0};
    localparam logic [31:0] I_ADD = {6'h00, 26'h20};

    mem_access_ctrl #(.TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST), .Ins(Ins), .Adr(Adr), .Wdata(Wdata),
        .Rdata(Rdata), .Stall(Stall), .Err(Err), .MReq(MReq), .MWe(MWe),
        .MAdr(MAdr), .MWdata(MWdata), .MGnt(MGnt), .MRvalid(MRvalid), .MRdata(MRdata)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // gnt_at<0: never grant; otherwise MGnt held high from cycle gnt_at on
    task automatic run_op(input logic [31:0] ins, input logic [31:0] adr, input logic [31:0] wd,
                          input int gnt_at, input int rv_at, input logic [31:0] rv_data,
                          output int n_stall, output int n_req, output logic [31:0] rd,
                          output logic we, output logic [31:0] ma, output logic [31:0] mw,
                          output logic stable);
        logic done;
        done = 1'b0; n_stall = 0; n_req = 0; rd = 'x; we = 1'b0; ma = 'x; mw = 'x; stable = 1'b1;
        Ins = ins; Adr = adr; Wdata = wd;
        for (int i = 0; i < 40 && !done; i++) begin
            MGnt    = gnt_at >= 0 && i >= gnt_at;
            MRvalid = i == rv_at;
            MRdata  = i == rv_at ? rv_data : 32'h0BAD0BAD;
            @(negedge CLK);
            if (MReq) begin
                if (n_req > 0 && (MAdr !== ma || MWdata !== mw || MWe !== we)) stable = 1'b0;
                n_req++; we = MWe; ma = MAdr; mw = MWdata;
            end
            if (Stall) n_stall++;
            else begin
                done = 1'b1;
                rd = Rdata;
            end
            step();
        end
        if (!done) check("op_done_bound", 32'd0, 32'd1);
        Ins = I_ADD; Adr = 32'h0; MGnt = 1'b0; MRvalid = 1'b0;
    endtask

    int n_stall, n_req, n_late;
    logic [31:0] rd, ma, mw;
    logic we, stable;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(); step();
        @(negedge CLK);
        check("rst_mreq", MReq, 0);
        check("rst_err", Err, 0);
        check("rst_madr", MAdr, 0);
        check("rst_mwdata", MWdata, 0);
        step();
        RST = 1'b0;

        Ins = I_ADD; Adr = 32'h1234; n_late = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (MReq || Stall || Rdata !== 32'h1234) n_late++;
            step();
        end
        @(negedge CLK);
        check("add_stall", Stall, 0);
        check("add_rdata", Rdata, 32'h1234);
        check("add_quiet_cycles", n_late, 0);
        step();

        run_op(I_SW, 32'h10, 32'hA5A5A5A5, 0, -1, 0, n_stall, n_req, rd, we, ma, mw, stable);
        check("sw_stall", n_stall, 2);
        check("sw_nreq", n_req, 1);
        check("sw_mwe", we, 1);
        check("sw_madr", ma, 32'h10);
        check("sw_mwdata", mw, 32'hA5A5A5A5);
        check("sw_rdata", rd, 0);

        run_op(I_LW, 32'h20, 32'h0, 4, 6, 32'hCAFEF00D, n_stall, n_req, rd, we, ma, mw, stable);
        check("lw_nreq", n_req, 4);
        check("lw_madr", ma, 32'h20);
        check("lw_mwe", we, 0);
        check("lw_stable", stable, 1);
        check("lw_stall", n_stall, 7);
        check("lw_rdata", rd, 32'hCAFEF00D);
        check("lw_err", Err, 0);
        n_late = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (MReq) n_late++;
            step();
        end
        check("lw_no_reissue", n_late, 0);

        run_op(I_LW, 32'h22, 32'h0, 0, -1, 0, n_stall, n_req, rd, we, ma, mw, stable);
        check("mis_nreq", n_req, 0);
        check("mis_stall", n_stall, 1);
        check("mis_rdata", rd, 32'hDEADBEEF);
        @(negedge CLK);
        check("mis_err", Err, 1);
        step();

        run_op(I_LW, 32'h30, 32'h0, 0, -1, 0, n_stall, n_req, rd, we, ma, mw, stable);
        check("to_stall_range", n_stall >= 10 && n_stall <= 11, 1);
        check("to_rdata", rd, 32'hDEADBEEF);
        Adr = 32'h77; MRvalid = 1'b1; MRdata = 32'h11111111;
        @(negedge CLK);
        check("to_late_rdata", Rdata, 32'h77);
        check("to_late_stall", Stall, 0);
        check("to_err_sticky", Err, 1);
        step();
        MRvalid = 1'b0;

        Ins = I_LW; Adr = 32'h40; MGnt = 1'b1;
        step(); step();
        MGnt = 1'b0;
        @(negedge CLK);
        check("rst_mid_wait_stall", Stall, 1);
        check("rst_mid_wait_mreq", MReq, 0);
        step();
        RST = 1'b1; Ins = I_ADD; Adr = 32'h55;
        step();
        RST = 1'b0; MRvalid = 1'b1; MRdata = 32'h22222222;
        @(negedge CLK);
        check("rst_mid_mreq", MReq, 0);
        check("rst_mid_stall", Stall, 0);
        check("rst_mid_err", Err, 0);
        check("rst_mid_rdata", Rdata, 32'h55);
        step();
        MRvalid = 1'b0;
        @(negedge CLK);
        check("rst_mid_rv_ignored", Rdata, 32'h55);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
